reset_handshake_tx: RTL and testbench

Initiator side of a cross-domain reset handshake. Runs in the controlling domain and drives a reset line into a downstream domain. It holds that reset for a minimum number of cycles, then waits for the downstream domain to confirm it is in reset. It releases the reset, waits for the downstream domain to confirm release, and reports completion. The downstream domain's reset synchronizer is the receiving end; its synchronized reset level is returned here as `rst_ack_async`.

---
 rtl/reset_handshake_tx.sv | 140 ++++++++++++++
 tb/tb_reset_handshake_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_handshake_tx.sv
// reset_handshake_tx: initiator side of a cross-domain reset handshake.
// Holds rst_out for MIN_ASSERT_CYCLES, waits for the downstream domain to
// report it is in reset, releases, waits for the downstream release, then
// reports completion (rst_done) until the next sw_rst_req.
// Optional feature macro: RST_HS_TIMEOUT_EN (bounds each acknowledge wait
// to ACK_TIMEOUT cycles and raises a sticky rst_timeout flag on expiry).
module reset_handshake_tx #(
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int ACK_TIMEOUT       = 1024,
  parameter int SYNC_STAGES       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_rst_req,
  input  logic rst_ack_async,
  output logic rst_out,
  output logic rst_done,
  output logic busy,
  output logic rst_timeout
);

  localparam int CW = $clog2(MIN_ASSERT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_ASSERT_CYCLES);

  // Reject illegal configurations at elaboration time.
  if (MIN_ASSERT_CYCLES < 1) begin : g_bad_min
    $error("MIN_ASSERT_CYCLES must be >= 1");
  end
  if (ACK_TIMEOUT < 2) begin : g_bad_tmo
    $error("ACK_TIMEOUT must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_ACK_HI  = 2'd1,
    S_RELEASE = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rst_out_q;
  logic          rst_done_q;
  logic          busy_q;
  logic          ack_s;
  logic          tmo_hit;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  // Synchronize the downstream reset level into this clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rst_ack_async};
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

`ifdef RST_HS_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] tcnt_q;
  logic          rst_timeout_q;
  logic          waiting;

  // Still waiting on the acknowledge that ends the current state.
  assign waiting = ((state_q == S_ACK_HI) && !ack_s) ||
                   ((state_q == S_RELEASE) && ack_s);
  assign tmo_hit = (tcnt_q == TMO_LAST);

  // Wait-cycle counter (zero on every state entry) and sticky timeout flag.
  // A matching ack drops 'waiting', so ack beats a same-cycle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q        <= '0;
      rst_timeout_q <= 1'b0;
    end else begin
      if (waiting && !tmo_hit) tcnt_q <= tcnt_q + 1'b1;
      else                     tcnt_q <= '0;
      if ((state_q == S_READY) && sw_rst_req) rst_timeout_q <= 1'b0;
      else if (waiting && tmo_hit)            rst_timeout_q <= 1'b1;
    end
  end

  assign rst_timeout = rst_timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign rst_timeout = 1'b0;
`endif

  // Handshake FSM; outputs are registered and change with the transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      rst_out_q  <= 1'b1;
      rst_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_ASSERT: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_ACK_HI;
        end
        S_ACK_HI: begin
          if (ack_s || tmo_hit) begin
            state_q   <= S_RELEASE;
            rst_out_q <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!ack_s || tmo_hit) begin
            state_q    <= S_READY;
            rst_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        S_READY: begin
          if (sw_rst_req) begin
            state_q    <= S_ASSERT;
            cnt_q      <= '0;
            rst_out_q  <= 1'b1;
            rst_done_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: state_q <= S_ASSERT;
      endcase
    end
  end

  assign rst_out  = rst_out_q;
  assign rst_done = rst_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reset_handshake_tx.sv
// Bench for reset_handshake_tx: two instances (default hold length with a
// short timeout, and a one-cycle hold) checked by directed tasks and by a
// randomized run against a phase/deadline reference model.
module tb_reset_handshake_tx;

  localparam int MIN0 = 16;
  localparam int MIN1 = 1;
  localparam int TO0  = 8;
  localparam int TO1  = 1024;
  localparam int SYNC = 2;
`ifdef RST_HS_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif

  localparam int P_HOLD = 0, P_WHI = 1, P_WLO = 2, P_IDLE = 3;

  logic clk = 1'b0;
  logic rst, req0, req1, ack0, ack1;
  logic ro0, done0, busy0, to0;
  logic ro1, done1, busy1, to1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_handshake_tx #(.MIN_ASSERT_CYCLES(MIN0), .ACK_TIMEOUT(TO0), .SYNC_STAGES(SYNC)) u_dut0 (
    .clk(clk), .rst(rst), .sw_rst_req(req0), .rst_ack_async(ack0),
    .rst_out(ro0), .rst_done(done0), .busy(busy0), .rst_timeout(to0));

  reset_handshake_tx #(.MIN_ASSERT_CYCLES(MIN1), .ACK_TIMEOUT(TO1), .SYNC_STAGES(SYNC)) u_dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(req1), .rst_ack_async(ack1),
    .rst_out(ro1), .rst_done(done1), .busy(busy1), .rst_timeout(to1));

  // Downstream stand-in for instance 0: rst_out echoed back after ack_dly
  // cycles, optionally with one-cycle glitches; or held at 0.
  int ack_mode = 0;   // 0 follow, 1 force low
  int ack_dly  = 3;
  bit glitch_en = 1'b0;
  bit roq[$];

  always @(posedge clk) begin
    #2;
    roq.push_back(ro0);
    if (roq.size() > 16) void'(roq.pop_front());
    if (ack_mode == 0) begin
      ack0 = (roq.size() > ack_dly) ? roq[roq.size()-1-ack_dly] : 1'b1;
      if (glitch_en && $urandom_range(15) == 0) ack0 = ~ack0;
    end else begin
      ack0 = 1'b0;
    end
  end

  // Reference model: phase per instance, with deadlines counted from the
  // edge the phase began; the ack seen at edge e is the input sampled at
  // edge e-SYNC.
  int ecount = -1;
  int ph[2]  = '{P_HOLD, P_HOLD};
  int t0[2]  = '{0, 0};
  bit mto[2] = '{1'b0, 1'b0};
  int mins[2] = '{MIN0, MIN1};
  int tos[2]  = '{TO0, TO1};
  bit hq0[$];
  bit hq1[$];

  task automatic model_step(input int i, input bit a, input bit rq);
    case (ph[i])
      P_HOLD:
        if (ecount - t0[i] == mins[i] - 1) begin ph[i] = P_WHI; t0[i] = ecount + 1; end
      P_WHI:
        if (a) begin ph[i] = P_WLO; t0[i] = ecount + 1; end
        else if (TOEN && (ecount - t0[i] == tos[i] - 1)) begin
          mto[i] = 1'b1; ph[i] = P_WLO; t0[i] = ecount + 1;
        end
      P_WLO:
        if (!a) ph[i] = P_IDLE;
        else if (TOEN && (ecount - t0[i] == tos[i] - 1)) begin
          mto[i] = 1'b1; ph[i] = P_IDLE;
        end
      default:
        if (rq) begin ph[i] = P_HOLD; t0[i] = ecount + 1; mto[i] = 1'b0; end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecount = -1;
      for (int i = 0; i < 2; i++) begin ph[i] = P_HOLD; t0[i] = 0; mto[i] = 1'b0; end
      hq0.delete();
      hq1.delete();
    end else begin
      bit a0, a1;
      ecount++;
      a0 = (hq0.size() >= SYNC) ? hq0[hq0.size()-SYNC] : 1'b0;
      a1 = (hq1.size() >= SYNC) ? hq1[hq1.size()-SYNC] : 1'b0;
      hq0.push_back(ack0);
      hq1.push_back(ack1);
      if (hq0.size() > 8) void'(hq0.pop_front());
      if (hq1.size() > 8) void'(hq1.pop_front());
      model_step(0, a0, req0);
      model_step(1, a1, req1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ack1 = 1'b1;
    ack_mode = 0; ack_dly = 3; glitch_en = 1'b0;
    repeat (4) step();
    checks++;
    if ({ro0, done0, busy0, to0} !== 4'b1010) begin
      failures++; $display("FAIL reset_out0 got=%b exp=1010", {ro0, done0, busy0, to0});
    end
    checks++;
    if ({ro1, done1, busy1, to1} !== 4'b1010) begin
      failures++; $display("FAIL reset_out1 got=%b exp=1010", {ro1, done1, busy1, to1});
    end
  endtask

  task automatic test_powerup();
    int n;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin step(); n++; if (!ro0) break; end
    checks++;
    if (n !== MIN0 + 1) begin
      failures++; $display("FAIL powerup_hold edges=%0d exp=%0d", n, MIN0 + 1);
    end
    n = 0;
    for (int k = 0; k < 100; k++) begin step(); n++; if (done0) break; end
    checks++;
    if (n !== 6) begin
      failures++; $display("FAIL powerup_fall_to_done edges=%0d exp=6", n);
    end
    checks++;
    if ({busy0, to0, ro0} !== 3'b000) begin
      failures++; $display("FAIL powerup_ready got=%b exp=000", {busy0, to0, ro0});
    end
  endtask

  task automatic test_sw_req();
    int hi, n;
    req0 = 1'b1; step(); req0 = 1'b0;
    checks++;
    if ({ro0, busy0, done0} !== 3'b110) begin
      failures++; $display("FAIL swreq_start got=%b exp=110", {ro0, busy0, done0});
    end
    hi = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      req0 = (k == 2);
      if (ro0) hi++; else break;
    end
    req0 = 1'b0;
    checks++;
    if (hi !== MIN0 + 1) begin
      failures++; $display("FAIL swreq_hold cycles=%0d exp=%0d", hi, MIN0 + 1);
    end
    n = 0;
    for (int k = 0; k < 100; k++) begin step(); n++; if (done0) break; end
    checks++;
    if (n !== 6) begin
      failures++; $display("FAIL swreq_fall_to_done edges=%0d exp=6", n);
    end
    repeat (10) step();
    checks++;
    if ({done0, ro0} !== 2'b10) begin
      failures++; $display("FAIL swreq_not_queued got=%b exp=10", {done0, ro0});
    end
  endtask

  task automatic test_min1();
    int n, hi;
    checks++;
    if ({ro1, done1} !== 2'b00) begin
      failures++; $display("FAIL min1_in_release got=%b exp=00", {ro1, done1});
    end
    ack1 = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin step(); n++; if (done1) break; end
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL min1_release_latency edges=%0d exp=3", n);
    end
    ack1 = 1'b1;
    repeat (6) step();
    checks++;
    if (done1 !== 1'b1) begin
      failures++; $display("FAIL min1_ack_ignored_ready got=%b exp=1", done1);
    end
    req1 = 1'b1; step(); req1 = 1'b0;
    hi = ro1 ? 1 : 0;
    for (int k = 0; k < 50; k++) begin step(); if (ro1) hi++; else break; end
    checks++;
    if (hi !== MIN1 + 1) begin
      failures++; $display("FAIL min1_hold cycles=%0d exp=%0d", hi, MIN1 + 1);
    end
    repeat (10) step();
    checks++;
    if ({ro1, done1} !== 2'b00) begin
      failures++; $display("FAIL min1_wait_release got=%b exp=00", {ro1, done1});
    end
    ack1 = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin step(); n++; if (done1) break; end
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL min1_release_latency2 edges=%0d exp=3", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    req0 = 1'b1; step(); req0 = 1'b0;
    for (int k = 0; k < 100; k++) begin step(); if (!ro0) break; end
    checks++;
    if ({ro0, done0} !== 2'b00) begin
      failures++; $display("FAIL arst_reach_release got=%b exp=00", {ro0, done0});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ro0, done0, busy0} !== 3'b101) begin
      failures++; $display("FAIL arst_immediate got=%b exp=101", {ro0, done0, busy0});
    end
    repeat (2) step();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin step(); n++; if (!ro0) break; end
    checks++;
    if (n !== MIN0 + 1) begin
      failures++; $display("FAIL arst_restart_hold edges=%0d exp=%0d", n, MIN0 + 1);
    end
    for (int k = 0; k < 100; k++) begin step(); if (done0) break; end
    checks++;
    if (done0 !== 1'b1) begin
      failures++; $display("FAIL arst_complete got=%b exp=1", done0);
    end
  endtask

  task automatic test_no_ack();
    int bad, n;
    ack_mode = 1;
    repeat (4) step();
    req0 = 1'b1; step(); req0 = 1'b0;
`ifdef RST_HS_TIMEOUT_EN
    n = 1;
    for (int k = 0; k < 200; k++) begin step(); if (ro0) n++; else break; end
    checks++;
    if ({n, to0} !== {MIN0 + TO0, 1'b1}) begin
      failures++; $display("FAIL timeout_ack_hi cycles=%0d to=%b exp=%0d/1", n, to0, MIN0 + TO0);
    end
    step();
    checks++;
    if ({done0, to0} !== 2'b11) begin
      failures++; $display("FAIL timeout_ready got=%b exp=11", {done0, to0});
    end
    ack_mode = 0;
    req0 = 1'b1; step(); req0 = 1'b0;
    checks++;
    if ({to0, ro0} !== 2'b01) begin
      failures++; $display("FAIL timeout_clear got=%b exp=01", {to0, ro0});
    end
`else
    bad = -1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if ({ro0, to0, done0} !== 3'b100) begin bad = k; break; end
    end
    checks++;
    if (bad != -1) begin
      failures++; $display("FAIL no_timeout_hold cycle=%0d got=%b exp=100", bad, {ro0, to0, done0});
    end
    ack_mode = 0;
`endif
    n = 0;
    for (int k = 0; k < 200; k++) begin step(); n++; if (done0) break; end
    checks++;
    if (done0 !== 1'b1) begin
      failures++; $display("FAIL no_ack_recover got=%b exp=1 after %0d", done0, n);
    end
  endtask

  task automatic test_random();
    logic [3:0] got, exp;
    glitch_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? {ro0, done0, busy0, to0} : {ro1, done1, busy1, to1};
        exp = {ph[i] <= P_WHI, ph[i] == P_IDLE, ph[i] != P_IDLE, mto[i]};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL random_inst%0d cycle=%0d got=%b exp=%b", i, c, got, exp);
        end
      end
      if (rst) rst = 1'b0;
      req0 = ($urandom_range(9) == 0);
      req1 = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) ack1 = ~ack1;
      if ($urandom_range(63) == 0) ack_dly = $urandom_range(5, 1);
      if ($urandom_range(499) == 0) begin #2 rst = 1'b1; end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; glitch_en = 1'b0;
  endtask

  initial begin
    ack0 = 1'b0;
    test_reset();
    test_powerup();
    test_sw_req();
    test_min1();
    test_async_reset();
    test_no_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
